// File: rtl/ct_had_serial_sm_pkg.sv
// HAD serial frame shared definitions.
// Frame geometry and FSM state encoding.
package ct_had_serial_sm_pkg;

    localparam int HACR_W = 16;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HACR = 3'd1;
    localparam logic [2:0] ST_UPD  = 3'd2;
    localparam logic [2:0] ST_DEC  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_RD   = 3'd5;

endpackage

// File: rtl/ct_had_serial_shreg.sv
// HAD serial 64-bit shift register: parallel load, shift right, MSB serial in.
// Ports: forever_cpuclk, cpurst_b, load/load_data, shift/sin, q.
module ct_had_serial_shreg
    import ct_had_serial_sm_pkg::*;
(
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              sin,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {sin, q[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/ct_had_serial_sm.sv
// HAD serial-frame FSM: TAP bits -> HACR command -> 64-bit write or read phase.
// Ports: TAP start/strobe/tdi in, decoder rw/read data in; data, pulses, tdo, busy, err out.
module ct_had_serial_sm
    import ct_had_serial_sm_pkg::*;
(
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              tap_start,
    input  logic              tap_shift_vld,
    input  logic              tap_tdi,
    input  logic              ir_sm_hacr_rw,
    input  logic [DATA_W-1:0] regs_serial_data,
    output logic [DATA_W-1:0] serial_xx_data,
    output logic              sm_ir_update_hacr,
    output logic              sm_xx_wr_vld,
    output logic              sm_tdo,
    output logic              sm_busy,
    output logic              sm_frame_err
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_nxt;
    logic [DATA_W-1:0] sh_q;
    logic              sh_load;
    logic              sh_shift;
    logic              sh_sin;
    logic              wr_vld_q;
    logic              wr_vld_nxt;
    logic              err_q;
    logic              err_nxt;
    logic              strobe;

    // A start in the same cycle as a strobe discards the strobe.
    assign strobe = tap_shift_vld & ~tap_start;

    ct_had_serial_shreg u_shreg (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .load           (sh_load),
        .load_data      (regs_serial_data),
        .shift          (sh_shift),
        .sin            (sh_sin),
        .q              (sh_q)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        data_nxt   = data_reg;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_sin     = tap_tdi;
        wr_vld_nxt = 1'b0;
        err_nxt    = 1'b0;
        if (tap_start) begin
            state_nxt = ST_HACR;
            cnt_nxt   = '0;
            err_nxt   = (state != ST_IDLE);
        end else begin
            unique case (1'b1)
                (state == ST_HACR): begin
                    if (strobe) begin
                        sh_shift = 1'b1;
                        cnt_nxt  = cnt + 1'b1;
                        if (cnt == CNT_W'(HACR_W - 1)) begin
                            // Last bit bypasses the shifter straight into HACR.
                            data_nxt  = {{(DATA_W-HACR_W){1'b0}},
                                         tap_tdi,
                                         sh_q[DATA_W-1 -: HACR_W-1]};
                            state_nxt = ST_UPD;
                        end
                    end
                end
                (state == ST_UPD): begin
                    err_nxt   = strobe;
                    state_nxt = ST_DEC;
                end
                (state == ST_DEC): begin
                    err_nxt = strobe;
                    cnt_nxt = '0;
                    if (ir_sm_hacr_rw) begin
                        sh_load   = 1'b1;
                        state_nxt = ST_RD;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
                (state == ST_WR): begin
                    if (strobe) begin
                        sh_shift = 1'b1;
                        cnt_nxt  = cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            data_nxt   = {tap_tdi, sh_q[DATA_W-1:1]};
                            wr_vld_nxt = 1'b1;
                            state_nxt  = ST_IDLE;
                        end
                    end
                end
                (state == ST_RD): begin
                    sh_sin = 1'b0;
                    if (strobe) begin
                        sh_shift = 1'b1;
                        cnt_nxt  = cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            data_reg <= '0;
            wr_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            data_reg <= data_nxt;
            wr_vld_q <= wr_vld_nxt;
            err_q    <= err_nxt;
        end
    end

    assign serial_xx_data    = data_reg;
    assign sm_ir_update_hacr = (state == ST_UPD);
    assign sm_xx_wr_vld      = wr_vld_q;
    assign sm_tdo            = (state == ST_RD) & sh_q[0];
    assign sm_busy           = (state != ST_IDLE);
    assign sm_frame_err      = err_q;

endmodule

// File: tb/tb_ct_had_serial_sm.sv
// Bench for ct_had_serial_sm: vector table of frames plus corner sequences.
// Update/write pulses are scored against queues of expected data.
module tb_ct_had_serial_sm;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        tap_start;
    logic        tap_shift_vld;
    logic        tap_tdi;
    logic        ir_sm_hacr_rw;
    logic [63:0] regs_serial_data;
    logic [63:0] serial_xx_data;
    logic        sm_ir_update_hacr;
    logic        sm_xx_wr_vld;
    logic        sm_tdo;
    logic        sm_busy;
    logic        sm_frame_err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;

    logic [63:0] upd_q[$];
    logic [63:0] wr_q[$];

    typedef struct {
        logic [15:0] hacr;
        logic [63:0] din;
        logic        rd;
        logic [63:0] exp_upd;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    ct_had_serial_sm dut (
        .forever_cpuclk    (forever_cpuclk),
        .cpurst_b          (cpurst_b),
        .tap_start         (tap_start),
        .tap_shift_vld     (tap_shift_vld),
        .tap_tdi           (tap_tdi),
        .ir_sm_hacr_rw     (ir_sm_hacr_rw),
        .regs_serial_data  (regs_serial_data),
        .serial_xx_data    (serial_xx_data),
        .sm_ir_update_hacr (sm_ir_update_hacr),
        .sm_xx_wr_vld      (sm_xx_wr_vld),
        .sm_tdo            (sm_tdo),
        .sm_busy           (sm_busy),
        .sm_frame_err      (sm_frame_err)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Decoder model: captures HACR[15] on the update pulse.
    always @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) ir_sm_hacr_rw <= 1'b0;
        else if (sm_ir_update_hacr) ir_sm_hacr_rw <= serial_xx_data[15];
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge forever_cpuclk) begin
        if (cpurst_b === 1'b1) begin
            if (sm_ir_update_hacr) begin
                check("upd_expected", 64'(upd_q.size() != 0), 64'd1);
                if (upd_q.size() != 0)
                    check("upd_data", serial_xx_data, upd_q.pop_front());
            end
            if (sm_xx_wr_vld) begin
                check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0)
                    check("wr_data", serial_xx_data, wr_q.pop_front());
            end
            if (sm_frame_err) err_cnt++;
        end
    end

    task automatic cyc();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tap_shift_vld = 1'b1;
        tap_tdi = b;
        cyc();
        tap_shift_vld = 1'b0;
        tap_tdi = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic pulse_start();
        tap_start = 1'b1;
        cyc();
        tap_start = 1'b0;
    endtask

    task automatic send_hacr(input logic [15:0] h);
        for (int i = 0; i < 16; i++) send_bit(h[i]);
    endtask

    task automatic send_data(input logic [63:0] d);
        for (int i = 0; i < 64; i++) send_bit(d[i]);
    endtask

    task automatic check_idle_outs(input string name);
        check({name, "_busy"}, 64'(sm_busy), 64'd0);
        check({name, "_tdo"}, 64'(sm_tdo), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        int e0;

        vecs[0] = '{16'h0210, 64'hDEAD_BEEF_0123_4567, 1'b0,
                    64'h0210, 64'hDEAD_BEEF_0123_4567};
        vecs[1] = '{16'h8200, 64'h0000_0000_A5A5_0001, 1'b1,
                    64'h8200, 64'h0000_0000_A5A5_0001};
        vecs[2] = '{16'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    64'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{16'h8001, 64'h8000_0000_0000_0001, 1'b1,
                    64'h8001, 64'h8000_0000_0000_0001};
        vecs[4] = '{16'h0000, 64'h5A5A_C3C3_0F0F_9669, 1'b0,
                    64'h0000, 64'h5A5A_C3C3_0F0F_9669};

        cpurst_b = 1'b0;
        tap_start = 1'b0;
        tap_shift_vld = 1'b0;
        tap_tdi = 1'b0;
        regs_serial_data = '0;
        repeat (3) cyc();
        check("rst_data", serial_xx_data, 64'd0);
        check("rst_upd", 64'(sm_ir_update_hacr), 64'd0);
        check("rst_wr", 64'(sm_xx_wr_vld), 64'd0);
        check("rst_err", 64'(sm_frame_err), 64'd0);
        check_idle_outs("rst");
        cpurst_b = 1'b1;
        cyc();

        // Strobes in IDLE are ignored silently.
        send_bit(1'b1);
        check_idle_outs("idle_strobe");
        check("idle_strobe_err", 64'(err_cnt), 64'd0);

        for (int v = 0; v < 5; v++) begin
            regs_serial_data = vecs[v].din;
            upd_q.push_back(vecs[v].exp_upd);
            pulse_start();
            check("frame_busy", 64'(sm_busy), 64'd1);
            send_hacr(vecs[v].hacr);
            if (vecs[v].rd) begin
                for (int i = 0; i < 64; i++) begin
                    d = vecs[v].exp_out;
                    check("rd_tdo", 64'(sm_tdo), 64'(d[i]));
                    send_bit(1'b0);
                end
                check("rd_data_stable", serial_xx_data, vecs[v].exp_upd);
            end else begin
                wr_q.push_back(vecs[v].exp_out);
                send_data(vecs[v].din);
            end
            check_idle_outs("frame_end");
        end
        check("table_err", 64'(err_cnt), 64'd0);

        // Abort after 40 write bits, then a clean restart.
        upd_q.push_back(64'h0210);
        pulse_start();
        send_hacr(16'h0210);
        d = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 40; i++) send_bit(d[i]);
        pulse_start();
        cyc();
        check("abort_err", 64'(err_cnt), 64'd1);
        check("abort_busy", 64'(sm_busy), 64'd1);
        upd_q.push_back(64'h0011);
        wr_q.push_back(64'h1234_5678_9ABC_DEF0);
        send_hacr(16'h0011);
        send_data(64'h1234_5678_9ABC_DEF0);
        check_idle_outs("abort_end");

        // Start and strobe together: the strobe must not be shifted.
        e0 = err_cnt;
        upd_q.push_back(64'h0C35);
        wr_q.push_back(64'h0BAD_F00D_CAFE_0042);
        tap_start = 1'b1;
        tap_shift_vld = 1'b1;
        tap_tdi = 1'b1;
        cyc();
        tap_start = 1'b0;
        tap_shift_vld = 1'b0;
        tap_tdi = 1'b0;
        cyc();
        cyc();
        send_hacr(16'h0C35);
        send_data(64'h0BAD_F00D_CAFE_0042);
        check("same_cyc_err", 64'(err_cnt), 64'(e0));
        check_idle_outs("same_cyc_end");

        // Strobe injected while in DEC is dropped and flagged.
        e0 = err_cnt;
        upd_q.push_back(64'h0042);
        wr_q.push_back(64'h0123_4567_89AB_CDEF);
        pulse_start();
        for (int i = 0; i < 15; i++) send_bit(1'(16'h0042 >> i));
        tap_shift_vld = 1'b1;
        tap_tdi = 1'b0;
        cyc();
        tap_shift_vld = 1'b0;
        cyc();
        tap_shift_vld = 1'b1;
        tap_tdi = 1'b1;
        cyc();
        tap_shift_vld = 1'b0;
        tap_tdi = 1'b0;
        cyc();
        cyc();
        check("dec_err", 64'(err_cnt), 64'(e0 + 1));
        send_data(64'h0123_4567_89AB_CDEF);
        check_idle_outs("dec_end");

        // Async reset in the middle of a read.
        regs_serial_data = 64'hFFFF_FFFF_FFFF_FFFF;
        upd_q.push_back(64'h8200);
        pulse_start();
        send_hacr(16'h8200);
        for (int i = 0; i < 10; i++) begin
            check("rst_rd_tdo", 64'(sm_tdo), 64'd1);
            send_bit(1'b0);
        end
        #2;
        cpurst_b = 1'b0;
        #1;
        check("mid_rst_data", serial_xx_data, 64'd0);
        check("mid_rst_upd", 64'(sm_ir_update_hacr), 64'd0);
        check("mid_rst_wr", 64'(sm_xx_wr_vld), 64'd0);
        check("mid_rst_err", 64'(sm_frame_err), 64'd0);
        check_idle_outs("mid_rst");
        cyc();
        cpurst_b = 1'b1;
        cyc();
        cyc();
        check_idle_outs("post_rst");

        check("upd_q_left", 64'(upd_q.size()), 64'd0);
        check("wr_q_left", 64'(wr_q.size()), 64'd0);
        check("total_err", 64'(err_cnt), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
